// File: rtl/fifo_pkt_writer.sv
// Drains length-prefixed packets from the byte FIFO and writes
// their payload bytes into a ring buffer in packet RAM.
module fifo_pkt_writer #(
   parameter int pBITS   = 8,
   parameter int pADDR_W = 8,
   parameter int pCNT_W  = 16
) (
   input  logic               iclk,
   input  logic               ireset_n,
   input  logic               ienable,
   input  logic               ififo_empty,
   input  logic [pBITS-1:0]   ififo_data,
   output logic               ofifo_rd,
   output logic               omem_we,
   output logic [pADDR_W-1:0] omem_addr,
   output logic [pBITS-1:0]   omem_data,
   output logic               obusy,
   output logic               opkt_done,
   output logic [pBITS-1:0]   opkt_len,
   output logic [pCNT_W-1:0]  opkt_cnt,
   output logic               oerr
);

   typedef enum logic [1:0] {
      sIdle,
      sPayload,
      sDone
   } stateT;

   stateT              state;
   logic [pADDR_W-1:0] wptr;
   logic [pBITS-1:0]   remaining;
   logic [pBITS-1:0]   lenReg;

   always_comb begin
      ofifo_rd = 1'b0;
      unique case (state)
         sIdle:    ofifo_rd = ienable & ~ififo_empty;
         sPayload: ofifo_rd = ~ififo_empty;
         default:  ofifo_rd = 1'b0;
      endcase
   end

   assign obusy = (state != sIdle);

   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state     <= sIdle;
         wptr      <= '0;
         remaining <= '0;
         lenReg    <= '0;
         omem_we   <= 1'b0;
         omem_addr <= '0;
         omem_data <= '0;
         opkt_done <= 1'b0;
         opkt_len  <= '0;
         opkt_cnt  <= '0;
         oerr      <= 1'b0;
      end else begin
         omem_we   <= 1'b0;
         opkt_done <= 1'b0;
         oerr      <= 1'b0;
         unique case (state)
            sIdle: begin
               // A zero-length header carries no payload: flag and drop it
               if (ofifo_rd) begin
                  if (ififo_data == '0) begin
                     oerr <= 1'b1;
                  end else begin
                     remaining <= ififo_data;
                     lenReg    <= ififo_data;
                     state     <= sPayload;
                  end
               end
            end
            sPayload: begin
               if (ofifo_rd) begin
                  omem_we   <= 1'b1;
                  omem_addr <= wptr;
                  omem_data <= ififo_data;
                  wptr      <= wptr + 1'b1;
                  remaining <= remaining - 1'b1;
                  // Completion status lands together with the last write
                  if (remaining == pBITS'(1)) begin
                     state     <= sDone;
                     opkt_done <= 1'b1;
                     opkt_len  <= lenReg;
                     opkt_cnt  <= opkt_cnt + 1'b1;
                  end
               end
            end
            sDone: begin
               state <= sIdle;
            end
            default: begin
               state <= sIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Bench for fifo_pkt_writer: directed packet scenarios plus random
// traffic, checked against a packet-level model of the byte stream.
module tb_fifo_pkt_writer;

   localparam int BITS = 8;
   localparam int AW   = 4;
   localparam int CW   = 16;

   logic            iclk = 1'b0;
   logic            ireset_n = 1'b0;
   logic            ienable = 1'b0;
   logic            ififo_empty = 1'b1;
   logic [BITS-1:0] ififo_data = '0;
   logic            ofifo_rd;
   logic            omem_we;
   logic [AW-1:0]   omem_addr;
   logic [BITS-1:0] omem_data;
   logic            obusy;
   logic            opkt_done;
   logic [BITS-1:0] opkt_len;
   logic [CW-1:0]   opkt_cnt;
   logic            oerr;

   fifo_pkt_writer #(
      .pBITS  (BITS),
      .pADDR_W(AW),
      .pCNT_W (CW)
   ) dut (
      .iclk       (iclk),
      .ireset_n   (ireset_n),
      .ienable    (ienable),
      .ififo_empty(ififo_empty),
      .ififo_data (ififo_data),
      .ofifo_rd   (ofifo_rd),
      .omem_we    (omem_we),
      .omem_addr  (omem_addr),
      .omem_data  (omem_data),
      .obusy      (obusy),
      .opkt_done  (opkt_done),
      .opkt_len   (opkt_len),
      .opkt_cnt   (opkt_cnt),
      .oerr       (oerr)
   );

   always #5 iclk = ~iclk;

   int passed = 0;
   int total  = 0;

   logic [7:0] q[$];

   // Packet-level model: bytes still owed to the current packet,
   // next ring address, completed count, last completed length.
   int mRem, mWptr, mCnt, mLen, mLastLen;
   bit mDone;
   bit eWe, eDone, eErr;
   int eAddr, eData;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic modelReset();
      mRem = 0; mWptr = 0; mCnt = 0; mLen = 0; mLastLen = 0;
      mDone = 0; eWe = 0; eDone = 0; eErr = 0; eAddr = 0; eData = 0;
   endtask

   task automatic pushPkt(int len);
      q.push_back(8'(len));
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
   endtask

   task automatic checkRegs();
      check("mem_we", 32'(omem_we), 32'(eWe));
      if (eWe) begin
         check("mem_addr", 32'(omem_addr), 32'(eAddr));
         check("mem_data", 32'(omem_data), 32'(eData));
      end
      check("pkt_done", 32'(opkt_done), 32'(eDone));
      check("err", 32'(oerr), 32'(eErr));
      check("busy", 32'(obusy), 32'(mRem > 0 || mDone));
      check("pkt_cnt", 32'(opkt_cnt), 32'(mCnt));
      check("pkt_len", 32'(opkt_len), 32'(mLastLen));
   endtask

   // Called just after a falling edge; ends just after the next one.
   task automatic step(bit en, int stallPct);
      bit stall, expRd, pop;
      logic [7:0] popped;
      stall = ($urandom_range(0, 99) < stallPct);
      ienable = en;
      ififo_empty = (q.size() == 0) || stall;
      ififo_data = ififo_empty ? 8'($urandom) : q[0];
      #1;
      if (mDone) expRd = 0;
      else if (mRem > 0) expRd = !ififo_empty;
      else expRd = en && !ififo_empty;
      check("fifo_rd", 32'(ofifo_rd), 32'(expRd));
      pop = ofifo_rd && !ififo_empty;
      popped = ififo_data;
      @(posedge iclk);
      if (pop) void'(q.pop_front());
      eWe = 0; eDone = 0; eErr = 0; mDone = 0;
      if (pop) begin
         if (mRem == 0) begin
            if (popped == 0) eErr = 1;
            else begin
               mRem = popped;
               mLen = popped;
            end
         end else begin
            eWe = 1;
            eAddr = mWptr;
            eData = popped;
            mWptr = (mWptr + 1) % (1 << AW);
            mRem--;
            if (mRem == 0) begin
               eDone = 1;
               mDone = 1;
               mCnt = (mCnt + 1) % (1 << CW);
               mLastLen = mLen;
            end
         end
      end
      @(negedge iclk);
      checkRegs();
   endtask

   task automatic midReset();
      ienable = 0;
      ififo_empty = 1;
      #2 ireset_n = 0;
      #1;
      modelReset();
      checkRegs();
      check("rst_addr", 32'(omem_addr), 32'd0);
      check("rst_data", 32'(omem_data), 32'd0);
      check("rst_rd", 32'(ofifo_rd), 32'd0);
      @(negedge iclk);
      ireset_n = 1;
   endtask

   initial begin
      int guard;
      modelReset();
      ireset_n = 0;
      repeat (2) @(negedge iclk);
      checkRegs();
      check("rst_addr", 32'(omem_addr), 32'd0);
      check("rst_data", 32'(omem_data), 32'd0);
      ireset_n = 1;

      // Basic 3-byte packet
      q = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
      repeat (7) step(1, 0);
      check("t1_cnt", 32'(opkt_cnt), 32'd1);
      check("t1_len", 32'(opkt_len), 32'd3);

      // Zero-length header then a 2-byte packet
      q = '{8'h00, 8'h02, 8'h11, 8'h22};
      repeat (7) step(1, 0);
      check("t2_cnt", 32'(opkt_cnt), 32'd2);

      // FIFO runs dry mid-packet
      q = '{8'h04, 8'h01, 8'h02};
      repeat (4) step(1, 0);
      repeat (5) step(1, 100);
      q.push_back(8'h03);
      q.push_back(8'h04);
      repeat (4) step(1, 0);
      check("t3_cnt", 32'(opkt_cnt), 32'd3);

      // Enable low in IDLE, then dropped mid-packet
      q = '{8'h02, 8'h05, 8'h06};
      repeat (3) step(0, 0);
      step(1, 0);
      repeat (4) step(0, 0);
      check("t6_cnt", 32'(opkt_cnt), 32'd4);

      // Reset two bytes into a 5-byte packet
      q = '{8'h05, 8'h10, 8'h20, 8'h01, 8'h77};
      repeat (3) step(1, 0);
      midReset();
      repeat (4) step(1, 0);
      check("t5_cnt", 32'(opkt_cnt), 32'd1);
      check("t5_len", 32'(opkt_len), 32'd1);

      // Random traffic; small address space wraps repeatedly
      for (int i = 0; i < 1500; i++) begin
         if (q.size() < 8) pushPkt($urandom_range(0, 7));
         if ($urandom_range(0, 299) == 0) midReset();
         else step($urandom_range(0, 4) != 0, $urandom_range(0, 30));
      end

      // Drain, bounded
      guard = 0;
      while ((q.size() != 0 || mRem > 0 || mDone) && guard < 400) begin
         if (mRem > q.size()) pushPkt(0);
         step(1, 0);
         guard++;
      end
      check("drain_timeout", 32'(guard < 400), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
